// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types, sizing constants and the round-robin pick function
// used by the grant arbiter and its decoder.
package rr_arb_pkg;

   localparam int unsigned N    = 16;
   localparam int unsigned IDXW = 4;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_e;

   // First set request bit at or after ptr, wrapping from N-1 back to 0.
   function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0]    req,
                                                input logic [IDXW-1:0] ptr);
      logic [IDXW-1:0] pick;
      logic [IDXW-1:0] idx;
      logic            found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ptr + IDXW'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_decoder.sv
// Index-to-one-hot grant decoder; all-zero output while no grant is valid.
module grant_decoder
   import rr_arb_pkg::*;
(
   input  logic [IDXW-1:0] gnt_idx,
   input  logic            gnt_valid,
   output logic [N-1:0]    gnt
);

   always_comb begin
      gnt = '0;
      if (gnt_valid) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for one 16-way resource: grant held until done,
// request withdrawal or hold timeout, then priority rotates past the owner.
module rr_grant_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 255,
   parameter int unsigned CNTW     = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_valid,
   output logic            timeout
);

   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

   arb_state_e      state_q, state_n;
   logic [IDXW-1:0] ptr_q, ptr_n;
   logic [CNTW-1:0] hold_cnt_q, hold_cnt_n;
   logic [IDXW-1:0] idx_n;
   logic            valid_n;
   logic            timeout_n;
   logic            hold_hit;
   logic            owner_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_idx    <= '0;
         gnt_valid  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_n;
         ptr_q      <= ptr_n;
         hold_cnt_q <= hold_cnt_n;
         gnt_idx    <= idx_n;
         gnt_valid  <= valid_n;
         timeout    <= timeout_n;
      end
   end

   assign owner_req = req[gnt_idx];
   assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_n    = state_q;
      ptr_n      = ptr_q;
      hold_cnt_n = hold_cnt_q;
      idx_n      = gnt_idx;
      valid_n    = gnt_valid;
      timeout_n  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               idx_n      = rr_pick(req, ptr_q);
               valid_n    = 1'b1;
               hold_cnt_n = '0;
               state_n    = GRANT;
            end
         end
         GRANT: begin
            if (hold_cnt_q != '1) begin
               hold_cnt_n = hold_cnt_q + 1'b1;
            end
            if (done || !owner_req || hold_hit) begin
               valid_n = 1'b0;
               ptr_n   = gnt_idx + 1'b1;
               state_n = IDLE;
               // Timeout is reported only when the hold limit alone forced the release.
               timeout_n = hold_hit && !done && owner_req;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   grant_decoder u_grant_decoder (
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: cycle vector table plus reset,
// rotation and hold-timeout sequences on a second short-timeout instance.
module tb_rr_grant_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   logic [15:0] req_t = '0;
   logic        done_t = 1'b0;
   logic [15:0] gnt_t;
   logic [3:0]  gnt_idx_t;
   logic        gnt_valid_t;
   logic        timeout_t;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   rr_grant_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   rr_grant_arbiter #(.MAX_HOLD(4), .CNTW(8)) dut_t (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_t),
      .done      (done_t),
      .gnt       (gnt_t),
      .gnt_idx   (gnt_idx_t),
      .gnt_valid (gnt_valid_t),
      .timeout   (timeout_t)
   );

   typedef struct {
      logic [15:0] req;
      logic        done;
      logic [3:0]  idx;
      logic        valid;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_main(input string name, input logic [3:0] idx, input logic valid,
                           input logic to);
      logic [15:0] eg;
      eg = valid ? (16'h0001 << idx) : 16'h0000;
      chk({name, ".gnt"}, {16'h0, gnt}, {16'h0, eg});
      chk({name, ".idx"}, {28'h0, gnt_idx}, {28'h0, idx});
      chk({name, ".valid"}, {31'h0, gnt_valid}, {31'h0, valid});
      chk({name, ".timeout"}, {31'h0, timeout}, {31'h0, to});
   endtask

   task automatic chk_t(input string name, input logic [3:0] idx, input logic valid,
                        input logic to);
      logic [15:0] eg;
      eg = valid ? (16'h0001 << idx) : 16'h0000;
      chk({name, ".gnt"}, {16'h0, gnt_t}, {16'h0, eg});
      chk({name, ".idx"}, {28'h0, gnt_idx_t}, {28'h0, idx});
      chk({name, ".valid"}, {31'h0, gnt_valid_t}, {31'h0, valid});
      chk({name, ".timeout"}, {31'h0, timeout_t}, {31'h0, to});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{16'h0008, 1'b0, 4'd3,  1'b1};
      tbl[1]  = '{16'h0008, 1'b0, 4'd3,  1'b1};
      tbl[2]  = '{16'h0008, 1'b0, 4'd3,  1'b1};
      tbl[3]  = '{16'h0008, 1'b1, 4'd3,  1'b0};
      tbl[4]  = '{16'h0018, 1'b0, 4'd4,  1'b1};
      tbl[5]  = '{16'h0018, 1'b1, 4'd4,  1'b0};
      tbl[6]  = '{16'h2000, 1'b0, 4'd13, 1'b1};
      tbl[7]  = '{16'h2000, 1'b1, 4'd13, 1'b0};
      tbl[8]  = '{16'h0003, 1'b0, 4'd0,  1'b1};
      tbl[9]  = '{16'h0003, 1'b1, 4'd0,  1'b0};
      tbl[10] = '{16'h0003, 1'b0, 4'd1,  1'b1};
      tbl[11] = '{16'h0003, 1'b1, 4'd1,  1'b0};
      tbl[12] = '{16'h0080, 1'b0, 4'd7,  1'b1};
      tbl[13] = '{16'h0081, 1'b0, 4'd7,  1'b1};
      tbl[14] = '{16'h0001, 1'b0, 4'd7,  1'b0};
      tbl[15] = '{16'h0000, 1'b1, 4'd7,  1'b0};
      tbl[16] = '{16'h0000, 1'b1, 4'd7,  1'b0};
      tbl[17] = '{16'h0201, 1'b0, 4'd9,  1'b1};
      tbl[18] = '{16'h0201, 1'b1, 4'd9,  1'b0};
      tbl[19] = '{16'h0000, 1'b0, 4'd9,  1'b0};
      tbl[20] = '{16'h0040, 1'b0, 4'd6,  1'b1};
      tbl[21] = '{16'h0000, 1'b1, 4'd6,  1'b0};
      tbl[22] = '{16'h0000, 1'b0, 4'd6,  1'b0};

      // Reset values, then grant requester 5 and reset in mid-grant.
      tick();
      chk_main("reset", 4'd0, 1'b0, 1'b0);
      chk_t("reset_t", 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      req = 16'h0020;
      tick();
      chk_main("grant5", 4'd5, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_main("async_reset", 4'd0, 1'b0, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      chk_main("regrant5", 4'd5, 1'b1, 1'b0);

      // Rotation with all requesting, done pulsed in every grant cycle.
      rst_n = 1'b0;
      req = 16'hFFFF;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk_main($sformatf("rot%0d", k), 4'(k % 16), 1'b1, 1'b0);
         done = 1'b1;
         tick();
         chk_main($sformatf("rot%0d_idle", k), 4'(k % 16), 1'b0, 1'b0);
         done = 1'b0;
      end

      // Cycle vectors from ptr=0 idle.
      rst_n = 1'b0;
      req = '0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 23; i++) begin
         req  = tbl[i].req;
         done = tbl[i].done;
         tick();
         chk_main($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].valid, 1'b0);
      end
      req = '0;
      done = 1'b0;

      // Hold timeout on the MAX_HOLD=4 instance, then done on the limit cycle.
      req_t = 16'h0100;
      tick();
      chk_t("to_hold0", 4'd8, 1'b1, 1'b0);
      for (int c = 1; c < 4; c++) begin
         tick();
         chk_t($sformatf("to_hold%0d", c), 4'd8, 1'b1, 1'b0);
      end
      tick();
      chk_t("to_revoke", 4'd8, 1'b0, 1'b1);
      tick();
      chk_t("to_regrant", 4'd8, 1'b1, 1'b0);
      for (int c = 1; c < 4; c++) begin
         tick();
         chk_t($sformatf("to2_hold%0d", c), 4'd8, 1'b1, 1'b0);
      end
      done_t = 1'b1;
      tick();
      chk_t("to_done_prio", 4'd8, 1'b0, 1'b0);
      done_t = 1'b0;
      req_t = '0;
      tick();
      chk_t("to_quiet", 4'd8, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
